// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared state enum and byte helpers for sync_ram_bank
package mem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } mem_state_e;

  // Widest word be_merge can handle; callers zero-extend and truncate around it.
  localparam int MEM_MAX_W = 1024;

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

  function automatic logic [MEM_MAX_W-1:0] be_merge(
    input logic [MEM_MAX_W-1:0]   old_w,
    input logic [MEM_MAX_W-1:0]   new_w,
    input logic [MEM_MAX_W/8-1:0] be
  );
    logic [MEM_MAX_W-1:0] r;
    r = old_w;
    for (int i = 0; i < MEM_MAX_W/8; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/mem_par_chk.sv
// rtl/mem_par_chk.sv - combinational per-byte even-parity check over masked bytes
module mem_par_chk
  import mem_pkg::*;
#(
  parameter int BE_W = 1
) (
  input  logic [8*BE_W-1:0] data,
  input  logic [BE_W-1:0]   par,
  input  logic [BE_W-1:0]   mask,
  output logic              err
);

  always_comb begin
    err = 1'b0;
    for (int i = 0; i < BE_W; i++) begin
      if (mask[i] && (byte_parity(data[8*i +: 8]) != par[i])) err = 1'b1;
    end
  end

endmodule

// File: rtl/sync_ram_bank.sv
// rtl/sync_ram_bank.sv - byte-enabled RAM with registered read and init sweep
// Optional per-byte parity storage and checking enabled by defining PARITY_EN.
module sync_ram_bank
  import mem_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_en,
  input  logic [$clog2(DEPTH)-1:0]    wr_addr,
  input  logic [DATA_W-1:0]           w_data,
  input  logic [DATA_W/8-1:0]         wr_be,
  input  logic                        rd_en,
  input  logic [$clog2(DEPTH)-1:0]    rd_addr,
  output logic [DATA_W-1:0]           r_data,
  output logic                        r_valid,
  output logic                        busy,
  output logic                        addr_err,
  output logic                        par_err
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int BE_W   = DATA_W / 8;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] LAST_L  = (ADDR_W+1)'(DEPTH - 1);

  mem_state_e        state, next_state;
  logic [ADDR_W-1:0] ptr;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              init_last;
  logic              wr_in_range, rd_in_range;
  logic              wr_ok, rd_ok;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [BE_W-1:0]   mem_be;
  logic [BE_W-1:0]   bypass_be;
  logic [ADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] rd_raw;
  logic [DATA_W-1:0] rd_word;

  assign init_last   = ({1'b0, ptr} == LAST_L);
  assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
  assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
  assign wr_ok       = (state == READY) && wr_en && wr_in_range;
  assign rd_ok       = (state == READY) && rd_en;
  assign busy        = (state == INIT);

  // Write-first bypass: bytes written this cycle to the read address come from w_data.
  assign bypass_be = (wr_ok && (wr_addr == rd_addr)) ? wr_be : '0;
  assign rd_idx    = rd_in_range ? rd_addr : '0;
  assign rd_raw    = mem[rd_idx];
  assign rd_word   = DATA_W'(be_merge(MEM_MAX_W'(rd_raw), MEM_MAX_W'(w_data),
                                      (MEM_MAX_W/8)'(bypass_be)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    if (state == INIT) begin
      mem_we    = 1'b1;
      mem_addr  = ptr;
      mem_wdata = INIT_VAL;
      mem_be    = '1;
      if (init_last) next_state = READY;
    end else if (wr_ok) begin
      mem_we    = 1'b1;
      mem_addr  = wr_addr;
      mem_wdata = w_data;
      mem_be    = wr_be;
    end
  end

  // Array is never reset; writes are held off while rst is asserted.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr      <= '0;
      r_data   <= '0;
      r_valid  <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      if (state == INIT) ptr <= init_last ? '0 : ptr + ADDR_W'(1);
      r_valid  <= rd_ok;
      if (rd_ok) r_data <= rd_in_range ? rd_word : '0;
      addr_err <= (state == READY) &&
                  ((wr_en && !wr_in_range) || (rd_en && !rd_in_range));
    end
  end

`ifdef PARITY_EN
  logic [BE_W-1:0] par_mem [DEPTH];
  logic [BE_W-1:0] wr_par;
  logic [BE_W-1:0] rd_par;
  logic            chk_err;
  logic            par_err_q;

  always_comb begin
    wr_par = '0;
    for (int i = 0; i < BE_W; i++) wr_par[i] = byte_parity(mem_wdata[8*i +: 8]);
  end

  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      for (int i = 0; i < BE_W; i++) begin
        if (mem_be[i]) par_mem[mem_addr][i] <= wr_par[i];
      end
    end
  end

  assign rd_par = par_mem[rd_idx];

  mem_par_chk #(
    .BE_W (BE_W)
  ) u_par_chk (
    .data (rd_raw),
    .par  (rd_par),
    .mask (~bypass_be),
    .err  (chk_err)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_err_q <= 1'b0;
    else     par_err_q <= rd_ok && rd_in_range && chk_err;
  end

  assign par_err = par_err_q;
`else
  assign par_err = 1'b0;
`endif

endmodule

// File: doc/sync_ram_bank.md
# sync_ram_bank

Parametrised single-clock RAM with independent write and read ports, per-byte write enables, and a registered read with a valid strobe. It is the successor to the fixed 4×8 memory model. After reset, a hardware init sweep fills every entry with a known value. The block is the storage element for the memory subsystem and is driven directly by the bus-side controller.

## Interface
Parameters:
- DATA_W, default 8: word width; must be a multiple of 8.
- DEPTH, default 4: number of words; any value ≥ 2, not necessarily a power of 2.
- INIT_VAL, default 0: DATA_W-bit value written to every entry by the init sweep.
- Local parameters: ADDR_W = $clog2(DEPTH); BE_W = DATA_W/8.

Ports:
- clk, in, 1: the only clock; all logic samples on its rising edge.
- rst, in, 1: asynchronous, active-high reset.
- wr_en, in, 1: write request.
- wr_addr, in, ADDR_W: write address.
- w_data, in, DATA_W: write data.
- wr_be, in, BE_W: byte enables; bit i covers w_data[8i+7:8i].
- rd_en, in, 1: read request.
- rd_addr, in, ADDR_W: read address.
- r_data, out, DATA_W: registered read data.
- r_valid, out, 1: one-cycle pulse marking r_data as fresh.
- busy, out, 1: high while the init sweep runs; requests are ignored.
- addr_err, out, 1: one-cycle pulse when an accepted request has an address ≥ DEPTH.
- par_err, out, 1: one-cycle pulse alongside r_valid on a parity mismatch; tied to 0 without PARITY_EN.

## Operation
- The FSM has two states, INIT and READY.
- **Reset:** rst asserted forces state = INIT, init pointer = 0, r_data = 0, r_valid = 0, busy = 1, addr_err = 0, par_err = 0. Array contents are not reset directly.
- **INIT:**
  - Each cycle writes INIT_VAL (with parity, if enabled) to mem[ptr], then ptr increments.
  - When ptr = DEPTH−1, that write completes, busy falls, and the state moves to READY.
  - wr_en and rd_en are ignored: no write, no r_valid, no addr_err.
- **READY, write:** when wr_en = 1 and wr_addr < DEPTH, only the bytes with wr_be = 1 are updated. wr_be = 0 performs no write.
- **READY, read:** when rd_en = 1, r_data is loaded from mem[rd_addr] and r_valid = 1 on the next cycle. Without a read, r_data holds its value and r_valid = 0.
- **Read and write to the same address in the same cycle:** write-first, per byte. Enabled bytes return w_data; the remaining bytes return the old contents.
- **Out of range (address ≥ DEPTH):**
  - A write is dropped and addr_err pulses.
  - A read returns r_data = 0 with r_valid = 1 and addr_err = 1.
  - When both ports are out of range in the same cycle, addr_err pulses once.
- **Reset mid-operation:** the in-flight read is discarded, outputs take their reset values, and the init sweep restarts from address 0.

## Timing
- Read latency is 1 cycle: a request at edge N produces r_valid and r_data after edge N+1.
- Back-to-back reads on every cycle are supported at full throughput.
- Writes take effect at the accepting edge; a read at the next edge sees the new data.
- After rst deasserts, busy stays high for exactly DEPTH rising edges. The first request accepted is the one sampled at edge DEPTH+1.
- addr_err and par_err are registered and align with r_valid for reads. For writes, addr_err appears one cycle after the request.

## Configuration
- **PARITY_EN defined:**
  - Each byte stores one extra even-parity bit.
  - Parity is generated on write and on init.
  - On read, stored parity is checked, and par_err = 1 with r_valid if any byte mismatches.
  - Out-of-range reads never flag par_err.
  - For a write-first bypass, parity is checked only on the bytes that come from the array.
- **PARITY_EN undefined:** there is no parity storage and par_err is constant 0.

## Structure
- Shared package mem_pkg holds:
  - the state enum mem_state_e (INIT, READY);
  - the function byte_parity(logic [7:0]);
  - the helper function be_merge(old, new, be).
- One sub-module, mem_par_chk: combinational per-byte parity check, instantiated only under PARITY_EN.
- The array and FSM live in sync_ram_bank.

## Test plan
- **Init sweep:** DEPTH=4, INIT_VAL=8'hA5, release rst → busy high for 4 edges. Then read addresses 0–3 → each r_data = 8'hA5 with r_valid.
- **Basic write/read:** write 8'h04 to address 2 with be=1; read address 2 on the next cycle → r_data = 8'h04 one cycle after the read; r_valid is exactly 1 cycle wide.
- **Byte enables:** DATA_W=16; write 16'h1234 with be=2'b11, then 16'hABCD with be=2'b01; read → 16'h12CD.
- **Same-address collision:** write 16'hFFFF with be=2'b10 and read the same address in the same cycle, over stored 16'h12CD → r_data = 16'hFFCD.
- **Out of range:** DEPTH=5, read address 6 → r_data = 0, r_valid = 1, addr_err = 1. Write 8'h77 to address 7 → addr_err pulses and no location changes.
- **Reset and parity:** assert rst while a read is in flight → r_valid = 0, r_data = 0, busy = 1, and the sweep restarts. With PARITY_EN, force a flipped data bit by hierarchical deposit, then read → par_err = 1 together with r_valid.
